// File: rtl/sigma_delta_pkg.sv
// Shared types and helpers for the sigma-delta DAC sample path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sigma_delta_pkg;

  // Scheduler playback states; RAMP is only reachable in soft-mute builds.
  typedef enum logic [1:0] {
    PRIME = 2'd0,
    RUN   = 2'd1,
    RAMP  = 2'd2,
    MUTED = 2'd3
  } sched_state_t;

  // Offset-binary midscale code for a DAC of the given width.
  function automatic logic [63:0] dac_mid(input int unsigned bitlen);
    return 64'd1 << (bitlen - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_sample_fifo.sv
// Synchronous sample FIFO with occupancy count; push ignored when full, pop ignored when empty.
// Latency: pushed word visible at head one cycle after the push edge when the FIFO was empty.
// Backpressure: caller gates push with !full; full/level are registered, no pop-to-full bypass.
module sigma_delta_sample_fifo #(
  parameter  int WIDTH = 24,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // Storage needs no reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sigma_delta_dac_sched.sv
// Sample scheduler feeding sigma_delta_dac: primes a FIFO, plays one sample per DAC strobe, mutes to midscale.
// Latency: dac_input/underrun update on the edge after the dac_ready cycle; PRIME->RUN checked every clock.
// Backpressure: s_ready = !full && !rst from registered level only. Soft-mute ramp enabled by SD_DAC_SCHED_SOFT_MUTE_EN.
module sigma_delta_dac_sched
  import sigma_delta_pkg::*;
#(
  parameter  int DAC_BITLEN  = 24,
  parameter  int FIFO_DEPTH  = 8,
  parameter  int START_LEVEL = 4,
  parameter  int RAMP_SHIFT  = 4,
  localparam int LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DAC_BITLEN-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  mute,
  input  logic                  dac_ready,
  output logic [DAC_BITLEN-1:0] dac_input,
  output logic                  underrun,
  output logic [LW-1:0]         fifo_level,
  output logic                  muted
);

  localparam logic [DAC_BITLEN-1:0] MID       = DAC_BITLEN'(dac_mid(DAC_BITLEN));
  localparam logic [LW-1:0]         START_LVL = LW'(START_LEVEL);

  // Parameter legality, caught at elaboration.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if ((START_LEVEL < 1) || (START_LEVEL > FIFO_DEPTH)) begin : g_bad_start
    $error("START_LEVEL must be within 1..FIFO_DEPTH");
  end
  if ((RAMP_SHIFT < 1) || (RAMP_SHIFT > DAC_BITLEN - 1)) begin : g_bad_shift
    $error("RAMP_SHIFT must be within 1..DAC_BITLEN-1");
  end

  sched_state_t          state, state_next;
  logic [DAC_BITLEN-1:0] dac_next;
  logic                  underrun_next;
  logic                  fifo_pop;
  logic                  fifo_push;
  logic [DAC_BITLEN-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;

  assign s_ready   = !fifo_full && !rst;
  assign fifo_push = s_valid && s_ready;
  assign muted     = (state == MUTED);

  sigma_delta_sample_fifo #(
    .WIDTH (DAC_BITLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (s_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
  localparam logic [DAC_BITLEN:0] RAMP_THRESH = (DAC_BITLEN+1)'(1) << RAMP_SHIFT;

  logic signed [DAC_BITLEN:0] ramp_d;
  logic        [DAC_BITLEN:0] ramp_mag;
  logic                       ramp_small;
  logic [DAC_BITLEN-1:0]      ramp_val;

  // One geometric step toward midscale: subtract (output - MID) / 2**RAMP_SHIFT, floored.
  always_comb begin
    ramp_d     = $signed({1'b0, dac_input}) - $signed({1'b0, MID});
    ramp_mag   = ramp_d[DAC_BITLEN] ? $unsigned(-ramp_d) : $unsigned(ramp_d);
    ramp_small = (ramp_mag < RAMP_THRESH);
    ramp_val   = dac_input - DAC_BITLEN'(ramp_d >>> RAMP_SHIFT);
  end
`endif

  // Playback state register.
  always_ff @(posedge clk) begin
    if (rst) state <= PRIME;
    else     state <= state_next;
  end

  // Next state, FIFO pop and next DAC word; every strobe-driven change lands on the strobe's edge.
  always_comb begin
    state_next    = state;
    dac_next      = dac_input;
    underrun_next = 1'b0;
    fifo_pop      = 1'b0;
    case (state)
      PRIME: begin
        if (mute) begin
          state_next = MUTED;
          dac_next   = MID;
        end else if (fifo_level >= START_LVL) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (dac_ready) begin
          if (mute) begin
            // The sample due on this strobe is dropped.
            fifo_pop = !fifo_empty;
`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
            if (ramp_small) begin
              dac_next   = MID;
              state_next = MUTED;
            end else begin
              dac_next   = ramp_val;
              state_next = RAMP;
            end
`else
            dac_next   = MID;
            state_next = MUTED;
`endif
          end else if (fifo_empty) begin
            underrun_next = 1'b1;
            state_next    = PRIME;
          end else begin
            fifo_pop = 1'b1;
            dac_next = fifo_head;
          end
        end
      end
`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
      RAMP: begin
        // Once started the ramp always completes, even if mute drops.
        if (dac_ready) begin
          fifo_pop = !fifo_empty;
          if (ramp_small) begin
            dac_next   = MID;
            state_next = MUTED;
          end else begin
            dac_next = ramp_val;
          end
        end
      end
`endif
      MUTED: begin
        dac_next = MID;
        fifo_pop = dac_ready && !fifo_empty;
        if (!mute) state_next = PRIME;
      end
      default: begin
        state_next = PRIME;
      end
    endcase
  end

  // Registered DAC word and underrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_input <= MID;
      underrun  <= 1'b0;
    end else begin
      dac_input <= dac_next;
      underrun  <= underrun_next;
    end
  end

endmodule

// File: tb/tb_sigma_delta_dac_sched.sv
// Self-checking bench for sigma_delta_dac_sched: directed vector table, corner sequences, random vs model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: s_ready compared every cycle against the model's FIFO occupancy.
module tb_sigma_delta_dac_sched;

  localparam int          W      = 24;
  localparam int          DEPTH  = 8;
  localparam int          START  = 4;
  localparam int          SHIFT  = 4;
  localparam logic [23:0] MIDV   = 24'h800000;
`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
  localparam bit          SOFT   = 1'b1;
`else
  localparam bit          SOFT   = 1'b0;
`endif

  localparam int M_PRIME = 0;
  localparam int M_RUN   = 1;
  localparam int M_RAMP  = 2;
  localparam int M_MUTED = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mute;
  logic        dac_ready;
  logic [23:0] dac_input;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic        muted;

  always #5 clk = ~clk;

  sigma_delta_dac_sched #(
    .DAC_BITLEN  (W),
    .FIFO_DEPTH  (DEPTH),
    .START_LEVEL (START),
    .RAMP_SHIFT  (SHIFT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .mute       (mute),
    .dac_ready  (dac_ready),
    .dac_input  (dac_input),
    .underrun   (underrun),
    .fifo_level (fifo_level),
    .muted      (muted)
  );

  int n_pass = 0;
  int n_tot  = 0;

  // Behavioural model: a sample queue, a playback mode and the current output word.
  logic [23:0] m_q[$];
  int          m_mode  = M_PRIME;
  logic [23:0] m_out   = MIDV;
  bit          m_under = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Move the output 1/16 of the way to midscale (rounded toward -inf), snapping when within 16 codes.
  task automatic ramp_step();
    int d;
    int ad;
    int stp;
    int nv;
    d  = int'(m_out) - int'(MIDV);
    ad = (d < 0) ? -d : d;
    if (ad < (1 << SHIFT)) begin
      m_out  = MIDV;
      m_mode = M_MUTED;
    end else begin
      stp    = (d >= 0) ? d / (1 << SHIFT) : -((-d + (1 << SHIFT) - 1) / (1 << SHIFT));
      nv     = int'(m_out) - stp;
      m_out  = nv[23:0];
      m_mode = M_RAMP;
    end
  endtask

  task automatic model_update(input bit r, input bit sv, input logic [23:0] sd, input bit mu, input bit dr);
    int pre;
    bit take;
    bit drop;
    pre     = m_q.size();
    take    = 1'b0;
    drop    = 1'b0;
    m_under = 1'b0;
    if (r) begin
      m_q.delete();
      m_mode = M_PRIME;
      m_out  = MIDV;
      return;
    end
    case (m_mode)
      M_PRIME: begin
        if (mu) begin
          m_mode = M_MUTED;
          m_out  = MIDV;
        end else if (pre >= START) m_mode = M_RUN;
      end
      M_RUN: if (dr) begin
        if (mu) begin
          drop = (pre > 0);
          if (SOFT) ramp_step();
          else begin
            m_out  = MIDV;
            m_mode = M_MUTED;
          end
        end else if (pre == 0) begin
          m_under = 1'b1;
          m_mode  = M_PRIME;
        end else begin
          m_out = m_q[0];
          take  = 1'b1;
        end
      end
      M_RAMP: if (dr) begin
        drop = (pre > 0);
        ramp_step();
      end
      default: begin
        m_out = MIDV;
        if (dr) drop = (pre > 0);
        if (!mu) m_mode = M_PRIME;
      end
    endcase
    if (take || drop) void'(m_q.pop_front());
    if (sv && (pre != DEPTH)) m_q.push_back(sd);
  endtask

  // One clock: drive, check s_ready, clock, advance model, check registered outputs.
  task automatic step(input bit r, input bit sv, input logic [23:0] sd, input bit mu, input bit dr);
    rst       = r;
    s_valid   = sv;
    s_data    = sd;
    mute      = mu;
    dac_ready = dr;
    #1;
    check("s_ready", {31'd0, s_ready}, {31'd0, (!r && (m_q.size() != DEPTH))});
    @(posedge clk);
    model_update(r, sv, sd, mu, dr);
    #1;
    check("dac_input", {8'd0, dac_input}, {8'd0, m_out});
    check("underrun", {31'd0, underrun}, {31'd0, m_under});
    check("fifo_level", {28'd0, fifo_level}, m_q.size());
    check("muted", {31'd0, muted}, {31'd0, (m_mode == M_MUTED)});
  endtask

  typedef struct {
    bit          sv;
    logic [23:0] sd;
    bit          dr;
    logic [23:0] exp_out;
    logic [3:0]  exp_lvl;
    bit          exp_under;
  } vec_t;

  vec_t        tbl[13];
  logic [23:0] fill_dat[8];
  bit          got;
  bit          mu_r;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; mute = 1'b0; dac_ready = 1'b0;
    @(posedge clk); #1;

    // Reset behaviour.
    step(1, 1, 24'hABCDEF, 0, 1);
    step(1, 0, 0, 0, 0);
    check("rst_s_ready_low", {31'd0, s_ready}, 32'd0);
    check("rst_dac_mid", {8'd0, dac_input}, {8'd0, MIDV});
    check("rst_level", {28'd0, fifo_level}, 32'd0);
    step(0, 0, 0, 0, 0);
    check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

    // Priming, playback order, PRIME ignores strobes, underrun on empty strobe.
    tbl[0]  = '{1, 24'h100000, 0, 24'h800000, 4'd1, 0};
    tbl[1]  = '{1, 24'h200000, 1, 24'h800000, 4'd2, 0};
    tbl[2]  = '{1, 24'h300000, 0, 24'h800000, 4'd3, 0};
    tbl[3]  = '{1, 24'h400000, 0, 24'h800000, 4'd4, 0};
    tbl[4]  = '{0, 24'h000000, 0, 24'h800000, 4'd4, 0};
    tbl[5]  = '{0, 24'h000000, 1, 24'h100000, 4'd3, 0};
    tbl[6]  = '{0, 24'h000000, 0, 24'h100000, 4'd3, 0};
    tbl[7]  = '{0, 24'h000000, 1, 24'h200000, 4'd2, 0};
    tbl[8]  = '{0, 24'h000000, 1, 24'h300000, 4'd1, 0};
    tbl[9]  = '{0, 24'h000000, 1, 24'h400000, 4'd0, 0};
    tbl[10] = '{0, 24'h000000, 0, 24'h400000, 4'd0, 0};
    tbl[11] = '{0, 24'h000000, 1, 24'h400000, 4'd0, 1};
    tbl[12] = '{0, 24'h000000, 0, 24'h400000, 4'd0, 0};
    for (int i = 0; i < 13; i++) begin
      step(0, tbl[i].sv, tbl[i].sd, 0, tbl[i].dr);
      check($sformatf("tbl%0d_out", i), {8'd0, dac_input}, {8'd0, tbl[i].exp_out});
      check($sformatf("tbl%0d_lvl", i), {28'd0, fifo_level}, {28'd0, tbl[i].exp_lvl});
      check($sformatf("tbl%0d_under", i), {31'd0, underrun}, {31'd0, tbl[i].exp_under});
    end

    // Full FIFO backpressure with a simultaneous pop.
    fill_dat = '{24'hFFFFFF, 24'h000010, 24'h7FFFF0, 24'h123456,
                 24'hABCDEF, 24'h000000, 24'h800001, 24'h654321};
    for (int i = 0; i < 8; i++) step(0, 1, fill_dat[i], 0, 0);
    check("full_level", {28'd0, fifo_level}, 32'd8);
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    step(0, 1, 24'h0A0A0A, 0, 1);
    check("full_pop_out", {8'd0, dac_input}, 32'hFFFFFF);
    check("full_pop_level", {28'd0, fifo_level}, 32'd7);
    check("full_pop_s_ready", {31'd0, s_ready}, 32'd1);
    step(0, 1, 24'h0A0A0A, 0, 0);
    check("refill_level", {28'd0, fifo_level}, 32'd8);

    // Mute from RUN at 0xFFFFFF: level mute alone does nothing until a strobe.
    step(0, 0, 0, 1, 0);
    check("mute_wait_out", {8'd0, dac_input}, 32'hFFFFFF);
    step(0, 0, 0, 1, 1);
    check("mute_strobe_level", {28'd0, fifo_level}, 32'd7);
`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
    check("ramp_first", {8'd0, dac_input}, 32'hF80000);
    check("ramp_not_muted", {31'd0, muted}, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 400 && !got; k++) begin
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
      if (muted) got = 1'b1;
    end
    check("ramp_converged", {31'd0, got}, 32'd1);
    check("ramp_end_mid", {8'd0, dac_input}, {8'd0, MIDV});
    check("ramp_drained", {28'd0, fifo_level}, 32'd0);
`else
    check("hard_mute_mid", {8'd0, dac_input}, {8'd0, MIDV});
    check("hard_mute_flag", {31'd0, muted}, 32'd1);
    for (int k = 0; k < 7; k++) begin
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 0);
    end
    check("mute_drained", {28'd0, fifo_level}, 32'd0);
`endif
    step(0, 0, 0, 0, 0);
    check("unmute_flag", {31'd0, muted}, 32'd0);

    // Resume after unmute needs a fresh prime.
    step(0, 1, 24'h111111, 0, 1);
    step(0, 1, 24'h222222, 0, 0);
    step(0, 1, 24'h333333, 0, 1);
    step(0, 1, 24'h444444, 0, 0);
    check("resume_prime_hold", {8'd0, dac_input}, {8'd0, MIDV});
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    check("resume_first", {8'd0, dac_input}, 32'h111111);

    // Reset in the middle of playback (mid-ramp in soft-mute builds).
`ifdef SD_DAC_SCHED_SOFT_MUTE_EN
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    check("ramp_ignores_unmute", {31'd0, muted}, 32'd0);
`else
    step(0, 0, 0, 0, 1);
`endif
    step(1, 0, 0, 0, 0);
    check("midrst_dac", {8'd0, dac_input}, {8'd0, MIDV});
    check("midrst_level", {28'd0, fifo_level}, 32'd0);
    check("midrst_muted", {31'd0, muted}, 32'd0);
    step(0, 0, 0, 0, 1);
    check("midrst_prime_hold", {8'd0, dac_input}, {8'd0, MIDV});

    // Random traffic against the model.
    mu_r = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) mu_r = !mu_r;
      step(($urandom_range(0, 699) == 0), $urandom_range(0, 1) == 1,
           24'($urandom), mu_r, ((k % 6) == 0) || ($urandom_range(0, 19) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
